ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_pkg.sv | 54 +++++
 rtl/ps2_event_fifo.sv | 61 ++++++
 rtl/ps2_scancode_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: FSM states, special
// byte values, modifier key codes and the event record stored in the FIFO.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } ps2_state_e;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;

  // Bytes that follow E1 before the pause sequence is complete.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int CODE_W  = 8;
  localparam int EVENT_W = CODE_W + 5;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              brk;
    logic              ext;
    logic              shift;
    logic              ctrl;
    logic              alt;
  } ps2_event_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == BYTE_00) || (b == BYTE_AA) || (b == BYTE_EE) ||
           (b == BYTE_FA) || (b == BYTE_FE) || (b == BYTE_FF);
  endfunction

  // Print-screen wraps itself in E0-prefixed shift codes that are not real keys.
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == KEY_LSHIFT) || (b == KEY_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; a push while full with no pop is dropped and
// flagged by a one-cycle overflow pulse.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [EVENT_W-1:0] i_din,
  input  logic               i_pop,
  output logic [EVENT_W-1:0] o_dout,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [EVENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = i_push && (!o_full || do_pop);

  // Head is forced to zero while empty so the event outputs idle at 0.
  assign o_dout = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= i_push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns a stream of PS/2 set-2 scan-code bytes into key make/break events
// with a modifier snapshot, queued in a small FIFO for the consumer.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_code,
  output logic       o_break,
  output logic       o_extended,
  output logic       o_shift,
  output logic       o_ctrl,
  output logic       o_alt,
  output logic       o_overflow,
  output logic [2:0] o_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  ps2_state_e       state, state_n;
  logic [2:0]       skip, skip_n;
  logic [TMO_W-1:0] tmo_cnt;
  logic             lshift, rshift, ctrl, alt;
  logic             lshift_n, rshift_n, ctrl_n, alt_n;
  logic             key_evt, key_brk, key_ext, pause_evt;
  ps2_event_t       ev_n, ev_q, head;
  logic             push_q;
  logic             fifo_empty, fifo_full, pop;

  assign o_state = state;

  always_comb begin
    state_n   = state;
    skip_n    = skip;
    key_evt   = 1'b0;
    key_brk   = 1'b0;
    key_ext   = 1'b0;
    pause_evt = 1'b0;
    if (i_data_valid) begin
      case (state)
        ST_IDLE: begin
          if (i_data == BYTE_E0) begin
            state_n = ST_EXT;
          end else if (i_data == BYTE_F0) begin
            state_n = ST_BRK;
          end else if (i_data == BYTE_E1) begin
            state_n = ST_PAUSE;
            skip_n  = PAUSE_SKIP;
          end else if (!is_ignored(i_data)) begin
            key_evt = 1'b1;
          end
        end
        ST_EXT: begin
          if (i_data == BYTE_F0) begin
            state_n = ST_EXT_BRK;
          end else begin
            state_n = ST_IDLE;
            key_evt = !is_fake_shift(i_data);
            key_ext = 1'b1;
          end
        end
        ST_BRK: begin
          state_n = ST_IDLE;
          key_evt = 1'b1;
          key_brk = 1'b1;
        end
        ST_EXT_BRK: begin
          state_n = ST_IDLE;
          key_evt = !is_fake_shift(i_data);
          key_brk = 1'b1;
          key_ext = 1'b1;
        end
        ST_PAUSE: begin
          if (skip == 3'd1) begin
            state_n   = ST_IDLE;
            skip_n    = 3'd0;
            pause_evt = 1'b1;
          end else begin
            skip_n = skip - 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Next modifier latches; the stored snapshot already includes this event.
  always_comb begin
    lshift_n = lshift;
    rshift_n = rshift;
    ctrl_n   = ctrl;
    alt_n    = alt;
    if (key_evt) begin
      case (i_data)
        KEY_LSHIFT: lshift_n = !key_brk;
        KEY_RSHIFT: rshift_n = !key_brk;
        KEY_CTRL:   ctrl_n   = !key_brk;
        KEY_ALT:    alt_n    = !key_brk;
        default:    ;
      endcase
    end
  end

  always_comb begin
    ev_n.code  = pause_evt ? BYTE_E1 : i_data;
    ev_n.brk   = key_brk && !pause_evt;
    ev_n.ext   = key_ext && !pause_evt;
    ev_n.shift = lshift_n || rshift_n;
    ev_n.ctrl  = ctrl_n;
    ev_n.alt   = alt_n;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      skip    <= '0;
      tmo_cnt <= '0;
      lshift  <= 1'b0;
      rshift  <= 1'b0;
      ctrl    <= 1'b0;
      alt     <= 1'b0;
      push_q  <= 1'b0;
      ev_q    <= '0;
    end else begin
      push_q <= key_evt || pause_evt;
      ev_q   <= ev_n;
      lshift <= lshift_n;
      rshift <= rshift_n;
      ctrl   <= ctrl_n;
      alt    <= alt_n;
      if (i_data_valid) begin
        state   <= state_n;
        skip    <= skip_n;
        tmo_cnt <= '0;
      end else if (state != ST_IDLE) begin
        // A stalled prefix is abandoned so a lost byte cannot poison later keys.
        if (tmo_cnt == TMO_MAX) begin
          state   <= ST_IDLE;
          skip    <= '0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign pop = o_valid && i_ready;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (push_q),
    .i_din      (ev_q),
    .i_pop      (pop),
    .o_dout     (head),
    .o_empty    (fifo_empty),
    .o_full     (fifo_full),
    .o_overflow (o_overflow)
  );

  assign o_valid    = !fifo_empty;
  assign o_code     = head.code;
  assign o_break    = head.brk;
  assign o_extended = head.ext;
  assign o_shift    = head.shift;
  assign o_ctrl     = head.ctrl;
  assign o_alt      = head.alt;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: byte driver, event scoreboard
// fed with hand-computed events, overflow counting and a final report.
module tb_ps2_scancode_decoder;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_code;
  logic       o_break;
  logic       o_extended;
  logic       o_shift;
  logic       o_ctrl;
  logic       o_alt;
  logic       o_overflow;
  logic [2:0] o_state;

  logic [12:0] exp_q[$];
  int checks;
  int failures;
  int ovf_cycles;
  bit mon_en;

  ps2_scancode_decoder #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (50000)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_code       (o_code),
    .o_break      (o_break),
    .o_extended   (o_extended),
    .o_shift      (o_shift),
    .o_ctrl       (o_ctrl),
    .o_alt        (o_alt),
    .o_overflow   (o_overflow),
    .o_state      (o_state)
  );

  // Clock and reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ev(input logic [7:0] code, input bit brk, input bit ext,
                                     input bit sh, input bit ct, input bit al);
    return {code, brk, ext, sh, ct, al};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_data       = b;
    i_data_valid = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic wait_drain(input string tag);
    repeat (4) @(negedge i_clk);
    for (int c = 0; c < 200 && (exp_q.size() != 0 || o_valid); c++) @(negedge i_clk);
    #2;
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every accepted head event is compared with the expected queue.
  always @(negedge i_clk) begin
    #1;
    if (o_overflow) ovf_cycles++;
    if (mon_en && o_valid && i_ready) begin
      if (exp_q.size() == 0) check_eq("extra_event", o_valid, 1'b0);
      else check_eq("event", {o_code, o_break, o_extended, o_shift, o_ctrl, o_alt},
                    exp_q.pop_front());
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    ovf_cycles = 0;
    mon_en = 1'b0;
    i_rst = 1'b1;
    i_data = 8'h00;
    i_data_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    #2;
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_fields", {o_code, o_break, o_extended, o_shift, o_ctrl, o_alt}, 13'h0);
    check_eq("rst_ovf", o_overflow, 1'b0);
    check_eq("rst_state", o_state, 3'd0);
    i_rst = 1'b0;

    // Latency: byte sampled at edge 1, event visible after edge 2.
    send_byte(8'h1C);
    #2;
    check_eq("lat_n1_valid", o_valid, 1'b0);
    @(negedge i_clk);
    #2;
    check_eq("lat_n2_valid", o_valid, 1'b1);
    check_eq("lat_n2_fields", {o_code, o_break, o_extended, o_shift, o_ctrl, o_alt},
             ev(8'h1C, 0, 0, 0, 0, 0));
    repeat (3) @(negedge i_clk);
    mon_en = 1'b1;

    exp_q.push_back(ev(8'h1C, 1, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h75, 1, 1, 0, 0, 0));
    send_seq('{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75});
    wait_drain("drain_break");

    exp_q.push_back(ev(8'h12, 0, 0, 1, 0, 0));
    exp_q.push_back(ev(8'h1C, 0, 0, 1, 0, 0));
    exp_q.push_back(ev(8'h12, 1, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    send_seq('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C});
    wait_drain("drain_shift");

    exp_q.push_back(ev(8'hE1, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
    wait_drain("drain_pause");

    // Print-screen fake shifts vanish; extended ctrl/alt drive the shared latches.
    exp_q.push_back(ev(8'h7C, 0, 1, 0, 0, 0));
    exp_q.push_back(ev(8'h7C, 1, 1, 0, 0, 0));
    exp_q.push_back(ev(8'h14, 0, 1, 0, 1, 0));
    exp_q.push_back(ev(8'h11, 0, 1, 0, 1, 1));
    exp_q.push_back(ev(8'h59, 0, 0, 1, 1, 1));
    exp_q.push_back(ev(8'h1C, 0, 0, 1, 1, 1));
    exp_q.push_back(ev(8'h14, 1, 1, 1, 0, 1));
    exp_q.push_back(ev(8'h11, 1, 0, 1, 0, 0));
    exp_q.push_back(ev(8'h59, 1, 0, 0, 0, 0));
    send_seq('{8'hE0, 8'h12, 8'hE0, 8'h7C, 8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12,
               8'hE0, 8'h14, 8'hE0, 8'h11, 8'h59, 8'hAA, 8'hFA, 8'h00, 8'h1C,
               8'hE0, 8'hF0, 8'h14, 8'hF0, 8'h11, 8'hF0, 8'h59});
    wait_drain("drain_mods");

    // Overflow: fifth event dropped while the consumer stalls.
    i_ready = 1'b0;
    ovf_cycles = 0;
    exp_q.push_back(ev(8'h15, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h16, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h1E, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h26, 0, 0, 0, 0, 0));
    send_seq('{8'h15, 8'h16, 8'h1E, 8'h26});
    repeat (2) @(negedge i_clk);
    #2;
    check_eq("full_no_ovf", ovf_cycles, 0);
    send_byte(8'h25);
    repeat (3) @(negedge i_clk);
    #2;
    check_eq("ovf_pulse", ovf_cycles, 1);
    check_eq("stall_valid", o_valid, 1'b1);
    check_eq("stall_head", o_code, 8'h15);
    repeat (5) @(negedge i_clk);
    #2;
    check_eq("stall_head_stable", o_code, 8'h15);
    @(negedge i_clk);
    i_ready = 1'b1;
    wait_drain("drain_ovf");

    // Push and pop on the same edge while full: both happen, no overflow.
    i_ready = 1'b0;
    ovf_cycles = 0;
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h1B, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h23, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h2B, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h2E, 0, 0, 0, 0, 0));
    send_seq('{8'h1C, 8'h1B, 8'h23, 8'h2B});
    repeat (3) @(negedge i_clk);
    i_data = 8'h2E;
    i_data_valid = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
    i_ready = 1'b1;
    wait_drain("drain_pushpop");
    check_eq("pushpop_no_ovf", ovf_cycles, 0);

    // Timeout abandons a dangling E0.
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    send_byte(8'hE0);
    #2;
    check_eq("tmo_in_ext", o_state, 3'd1);
    repeat (50010) @(negedge i_clk);
    #2;
    check_eq("tmo_back_idle", o_state, 3'd0);
    send_byte(8'h1C);
    wait_drain("drain_timeout");

    // Reset mid-prefix also clears the modifier latches.
    exp_q.push_back(ev(8'h12, 0, 0, 1, 0, 0));
    send_byte(8'h12);
    wait_drain("drain_pre_rst");
    send_byte(8'hE0);
    @(negedge i_clk);
    i_rst = 1'b1;
    #2;
    check_eq("rst_mid_state", o_state, 3'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    send_byte(8'h1C);
    wait_drain("drain_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
